// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared card types, deck constants and index helpers for the card shoe
package card_pkg;

    localparam int          DECK_SIZE      = 52;
    localparam int          RANKS_PER_SUIT = 13;
    localparam logic [5:0]  DECK_CNT       = 6'(DECK_SIZE);
    localparam logic [15:0] LFSR_MASK      = 16'hB400;

    typedef enum logic [1:0] {
        SUIT_CLUBS    = 2'd0,
        SUIT_DIAMONDS = 2'd1,
        SUIT_HEARTS   = 2'd2,
        SUIT_SPADES   = 2'd3
    } suit_t;

    // Presented card: rank 1 = Ace .. 13 = King.
    typedef struct packed {
        suit_t      suit;
        logic [3:0] rank;
    } card_t;

    // Blackjack value of a rank: Ace counts 1 here, faces count 10.
    function automatic logic [3:0] card_points(input logic [3:0] rank);
        if (rank >= 4'd10) begin
            return 4'd10;
        end
        return rank;
    endfunction

    // A 6-bit deck index {suit, rIdx} names a real card only for rIdx 0..12.
    function automatic logic is_legal(input logic [5:0] idx);
        return idx[3:0] < 4'(RANKS_PER_SUIT);
    endfunction

    // Next legal index after idx, modulo 64. From the last rank of a suit,
    // or from any illegal slot, hop straight to rank 0 of the next suit.
    function automatic logic [5:0] next_legal(input logic [5:0] idx);
        if (idx[3:0] >= 4'(RANKS_PER_SUIT - 1)) begin
            return {idx[5:4] + 2'd1, 4'd0};
        end
        return idx + 6'd1;
    endfunction

endpackage

// File: rtl/card_shoe_lfsr.sv
// rtl/card_shoe_lfsr.sv - free-running Galois LFSR with deal-button entropy mixing
//
// Ports:
//   i_clk        clock
//   i_reset_n    asynchronous active-low reset
//   i_seedPulse  deal-button level; each registered rising edge XORs the
//                cycle counter into the LFSR
//   o_lfsr       current 16-bit LFSR state (never zero)
module card_shoe_lfsr
    import card_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_seedPulse,
    output logic [15:0] o_lfsr
);

    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] cnt_q;
    logic [15:0] step;
    logic [15:0] mixed;
    logic        sync_q, prev_q;
    logic        seed_edge;

    // The button level is registered first; the edge is taken between two
    // registered samples so the mix never sees a raw asynchronous input.
    assign seed_edge = sync_q & ~prev_q;

    always_comb begin
        step   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        mixed  = lfsr_q ^ cnt_q;
        lfsr_d = step;
        if (seed_edge) begin
            // A zero state would lock the LFSR forever.
            lfsr_d = (mixed == 16'h0000) ? LFSR_SEED : mixed;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr_q <= LFSR_SEED;
            cnt_q  <= 16'h0000;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_q + 16'h0001;
            sync_q <= i_seedPulse;
            prev_q <= sync_q;
        end
    end

    assign o_lfsr = lfsr_q;

endmodule

// File: rtl/card_shoe.sv
// rtl/card_shoe.sv - single-deck card shoe, draws without replacement, one card per request
//
// Optional feature macro: CARD_SHOE_STACKED_DECK_EN (cards come out in index
// order instead of being picked by the LFSR).
//
// Ports:
//   i_clk             clock
//   i_reset_n         asynchronous active-low reset
//   i_drawReq         request one card (sampled only when idle)
//   i_shuffleReq      return all cards to the shoe
//   i_seedPulse       deal-button level, mixes entropy into the LFSR
//   o_cardValid       one-cycle pulse, o_card / o_cardPoints valid
//   o_card            {suit[1:0], rank[3:0]}, rank 1..13
//   o_cardPoints      blackjack value of o_card
//   o_busy            shoe is not idle
//   o_cardsRemaining  undealt cards, 0..52
//   o_shoeEmpty       no undealt cards left
module card_shoe
    import card_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int unsigned RESHUFFLE_AT = 0
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_drawReq,
    input  logic       i_shuffleReq,
    input  logic       i_seedPulse,
    output logic       o_cardValid,
    output logic [5:0] o_card,
    output logic [3:0] o_cardPoints,
    output logic       o_busy,
    output logic [5:0] o_cardsRemaining,
    output logic       o_shoeEmpty
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHUFFLE = 3'd1;
    localparam logic [2:0] S_PICK    = 3'd2;
    localparam logic [2:0] S_PROBE   = 3'd3;
    localparam logic [2:0] S_DELIVER = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [63:0] dealt_q, dealt_d;
    logic [5:0]  remain_q, remain_d;
    logic        pend_shuf_q, pend_shuf_d;
    logic        pend_draw_q, pend_draw_d;
    logic [5:0]  ptr_q, ptr_d;
    card_t       card_q, card_d;
    logic [3:0]  points_q, points_d;

    logic [15:0] lfsr;
    logic        lfsr_unused;
    logic [5:0]  cand;
    logic [5:0]  probe_nxt;
    logic        load;
    logic [5:0]  load_idx;
    logic        need_reshuffle;

    card_shoe_lfsr #(
        .LFSR_SEED   (LFSR_SEED)
    ) u_lfsr (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_seedPulse (i_seedPulse),
        .o_lfsr      (lfsr)
    );

    // Only the low bits pick a card; the rest of the state is deliberately dropped.
    assign lfsr_unused = ^lfsr;

`ifdef CARD_SHOE_STACKED_DECK_EN
    logic [5:0] stack_q, stack_d;
    assign cand = stack_q;
`else
    assign cand = lfsr[5:0];
`endif

    assign probe_nxt = next_legal(ptr_q);

    // Zero remaining always reshuffles, even when RESHUFFLE_AT is 0.
    assign need_reshuffle = (remain_q == 6'd0) || ({26'd0, remain_q} <= RESHUFFLE_AT);

    always_comb begin
        state_d     = state_q;
        dealt_d     = dealt_q;
        remain_d    = remain_q;
        pend_shuf_d = pend_shuf_q;
        pend_draw_d = pend_draw_q;
        ptr_d       = ptr_q;
        card_d      = card_q;
        points_d    = points_q;
        load        = 1'b0;
        load_idx    = ptr_q;
`ifdef CARD_SHOE_STACKED_DECK_EN
        stack_d     = stack_q;
`endif

        // A shuffle arriving mid-draw waits until the card is out.
        if (state_q != S_IDLE && i_shuffleReq) begin
            pend_shuf_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_shuf_q || i_shuffleReq) begin
                    state_d     = S_SHUFFLE;
                    pend_draw_d = pend_draw_q | i_drawReq;
                end else if (i_drawReq || pend_draw_q) begin
                    if (need_reshuffle) begin
                        state_d     = S_SHUFFLE;
                        pend_draw_d = 1'b1;
                    end else begin
                        state_d = S_PICK;
                    end
                end
            end
            S_SHUFFLE: begin
                dealt_d     = '0;
                remain_d    = DECK_CNT;
                pend_shuf_d = i_shuffleReq;
                state_d     = pend_draw_q ? S_PICK : S_IDLE;
`ifdef CARD_SHOE_STACKED_DECK_EN
                stack_d     = 6'd0;
`endif
            end
            S_PICK: begin
                ptr_d = cand;
                if (is_legal(cand) && !dealt_q[cand]) begin
                    load     = 1'b1;
                    load_idx = cand;
                    state_d  = S_DELIVER;
                end else begin
                    state_d = S_PROBE;
                end
            end
            S_PROBE: begin
                // probe_nxt is always legal; remaining > 0 guarantees a hit.
                ptr_d = probe_nxt;
                if (!dealt_q[probe_nxt]) begin
                    load     = 1'b1;
                    load_idx = probe_nxt;
                    state_d  = S_DELIVER;
                end
            end
            S_DELIVER: begin
                dealt_d[ptr_q] = 1'b1;
                remain_d       = remain_q - 6'd1;
                pend_draw_d    = 1'b0;
                state_d        = S_IDLE;
`ifdef CARD_SHOE_STACKED_DECK_EN
                stack_d        = next_legal(stack_q);
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output card is captured on entry to S_DELIVER so it is stable
        // for the whole o_cardValid cycle and holds afterwards.
        if (load) begin
            card_d.suit = suit_t'(load_idx[5:4]);
            card_d.rank = load_idx[3:0] + 4'd1;
            points_d    = card_points(load_idx[3:0] + 4'd1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            dealt_q     <= '0;
            remain_q    <= DECK_CNT;
            pend_shuf_q <= 1'b0;
            pend_draw_q <= 1'b0;
            ptr_q       <= 6'd0;
            card_q      <= '0;
            points_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            dealt_q     <= dealt_d;
            remain_q    <= remain_d;
            pend_shuf_q <= pend_shuf_d;
            pend_draw_q <= pend_draw_d;
            ptr_q       <= ptr_d;
            card_q      <= card_d;
            points_q    <= points_d;
        end
    end

`ifdef CARD_SHOE_STACKED_DECK_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stack_q <= 6'd0;
        end else begin
            stack_q <= stack_d;
        end
    end
`endif

    assign o_cardValid      = (state_q == S_DELIVER);
    assign o_card           = card_q;
    assign o_cardPoints     = points_q;
    assign o_busy           = (state_q != S_IDLE);
    assign o_cardsRemaining = remain_q;
    assign o_shoeEmpty      = (remain_q == 6'd0);

endmodule

// File: tb/tb_card_shoe.sv
// tb/tb_card_shoe.sv - directed self-checking bench for card_shoe
module tb_card_shoe;

    logic       clk = 1'b0;
    logic       rst_n, req0, req1, shuf, seed;
    logic       val0, busy0, empty0, val1, busy1, empty1;
    logic [5:0] card0, rem0, card1, rem1;
    logic [3:0] pts0, pts1;

    always #5 clk = ~clk;

    card_shoe dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_drawReq        (req0),
        .i_shuffleReq     (shuf),
        .i_seedPulse      (seed),
        .o_cardValid      (val0),
        .o_card           (card0),
        .o_cardPoints     (pts0),
        .o_busy           (busy0),
        .o_cardsRemaining (rem0),
        .o_shoeEmpty      (empty0)
    );

    card_shoe #(.RESHUFFLE_AT(10)) dut10 (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_drawReq        (req1),
        .i_shuffleReq     (shuf),
        .i_seedPulse      (seed),
        .o_cardValid      (val1),
        .o_card           (card1),
        .o_cardPoints     (pts1),
        .o_busy           (busy1),
        .o_cardsRemaining (rem1),
        .o_shoeEmpty      (empty1)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_points(input logic [3:0] rank);
        return (rank > 4'd9) ? 4'd10 : rank;
    endfunction

    // Results of the last draw
    logic       d_got, d_probe, d_saw52;
    int         d_lat;
    logic [5:0] d_card;
    logic [3:0] d_pts;
    logic [15:0] sv;

    // mode 0: plain draw; 1: pulse i_shuffleReq in the first PROBE cycle;
    // 2: assert reset in the first PROBE cycle and return.
    task automatic draw(input bit sel, input int mode);
        bit done;
        d_got = 0; d_probe = 0; d_saw52 = 0; d_lat = 0; done = 0;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        while (!done && d_lat < 60) begin
            @(posedge clk);
            @(negedge clk);
            d_lat++;
            shuf = 1'b0;
            if ((sel ? rem1 : rem0) == 6'd52) d_saw52 = 1;
            if (!sel && dut.state_q == 3'd3 && !d_probe) begin
                d_probe = 1;
                if (mode == 1) shuf = 1'b1;
                if (mode == 2) begin
                    rst_n = 1'b0;
                    done  = 1;
                end
            end
            if (sel ? val1 : val0) begin
                d_got  = 1;
                d_card = sel ? card1 : card0;
                d_pts  = sel ? pts1 : pts0;
                done   = 1;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        shuf = 1'b0;
        if (!done) check_vec("draw_timeout", 32'(d_lat), 32'd54);
        if (d_got) begin
            @(posedge clk);
            @(negedge clk);
            check_vec("valid_one_cycle", 32'(sel ? val1 : val0), 32'd0);
        end
    endtask

    bit seen [64];
    bit got_probe;
    bit any_valid;
    logic [5:0] idx;

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; shuf = 1'b0; seed = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        check_vec("rst_lfsr",   32'(dut.u_lfsr.lfsr_q), 32'hACE1);
        check_vec("rst_remain", 32'(rem0),   32'd52);
        check_vec("rst_valid",  32'(val0),   32'd0);
        check_vec("rst_card",   32'(card0),  32'd0);
        check_vec("rst_points", 32'(pts0),   32'd0);
        check_vec("rst_busy",   32'(busy0),  32'd0);
        check_vec("rst_empty",  32'(empty0), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check_vec("lfsr_first_step", 32'(dut.u_lfsr.lfsr_q), 32'hE270);

`ifdef CARD_SHOE_STACKED_DECK_EN
        begin
            int exp_pts [14] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10, 10, 10, 1};
            for (int i = 0; i < 14; i++) begin
                draw(0, 0);
                check_vec("stk_got",  32'(d_got), 32'd1);
                check_vec("stk_card", 32'(d_card), 32'({2'(i / 13), 4'((i % 13) + 1)}));
                check_vec("stk_pts",  32'(d_pts), 32'(exp_pts[i]));
                check_vec("stk_lat",  32'(d_lat), 32'd2);
            end
            check_vec("stk_remain", 32'(rem0), 32'd38);
            shuf = 1'b1;
            @(negedge clk);
            shuf = 1'b0;
            repeat (2) @(negedge clk);
            check_vec("stk_reshuffled", 32'(rem0), 32'd52);
        end
`endif

        // RESHUFFLE_AT = 10 instance
        for (int i = 0; i < 42; i++) draw(1, 0);
        check_vec("r10_last_no_shuffle", 32'(d_saw52), 32'd0);
        check_vec("r10_remain10", 32'(rem1), 32'd10);
        draw(1, 0);
        check_vec("r10_shuffle_seen", 32'(d_saw52), 32'd1);
        check_vec("r10_got", 32'(d_got), 32'd1);
        check_vec("r10_remain51", 32'(rem1), 32'd51);

        // Full deck: 52 distinct legal cards
        for (int i = 0; i < 64; i++) seen[i] = 0;
        for (int i = 0; i < 52; i++) begin
            draw(0, 0);
            check_vec("deal_got", 32'(d_got), 32'd1);
            check_vec("deal_lat_le54", 32'(d_lat <= 54), 32'd1);
            check_vec("deal_rank_legal", 32'(d_card[3:0] >= 4'd1 && d_card[3:0] <= 4'd13), 32'd1);
            check_vec("deal_points", 32'(d_pts), 32'(exp_points(d_card[3:0])));
            idx = {d_card[5:4], d_card[3:0] - 4'd1};
            check_vec("deal_distinct", 32'(seen[idx]), 32'd0);
            seen[idx] = 1;
            check_vec("deal_remain", 32'(rem0), 32'(51 - i));
        end
        check_vec("deck_empty", 32'(empty0), 32'd1);
        draw(0, 0);
        check_vec("d53_shuffle_seen", 32'(d_saw52), 32'd1);
        check_vec("d53_got", 32'(d_got), 32'd1);
        check_vec("d53_lat_le55", 32'(d_lat <= 55), 32'd1);
        check_vec("d53_remain51", 32'(rem0), 32'd51);
        check_vec("d53_not_empty", 32'(empty0), 32'd0);

`ifndef CARD_SHOE_STACKED_DECK_EN
        // Shuffle request during S_PROBE
        got_probe = 0;
        for (int k = 0; k < 52 && !got_probe; k++) begin
            draw(0, 1);
            if (d_probe) begin
                got_probe = 1;
                check_vec("sp_card_valid", 32'(d_got), 32'd1);
                check_vec("sp_rank_legal", 32'(d_card[3:0] >= 4'd1 && d_card[3:0] <= 4'd13), 32'd1);
                check_vec("sp_points", 32'(d_pts), 32'(exp_points(d_card[3:0])));
                @(negedge clk);
                check_vec("sp_shuffle_busy", 32'(busy0), 32'd1);
                @(negedge clk);
                check_vec("sp_remain52", 32'(rem0), 32'd52);
                check_vec("sp_idle", 32'(busy0), 32'd0);
            end
        end
        check_vec("sp_probe_reached", 32'(got_probe), 32'd1);

        // Reset during S_PROBE
        got_probe = 0;
        for (int k = 0; k < 52 && !got_probe; k++) begin
            draw(0, 2);
            if (d_probe) got_probe = 1;
        end
        check_vec("rp_probe_reached", 32'(got_probe), 32'd1);
        if (got_probe) begin
            any_valid = 0;
            repeat (3) begin
                @(negedge clk);
                if (val0) any_valid = 1;
            end
            rst_n = 1'b1;
            check_vec("rp_lfsr_seed", 32'(dut.u_lfsr.lfsr_q), 32'hACE1);
            check_vec("rp_remain52", 32'(rem0), 32'd52);
            repeat (3) begin
                @(negedge clk);
                if (val0) any_valid = 1;
            end
            check_vec("rp_no_valid", 32'(any_valid), 32'd0);
            check_vec("rp_idle", 32'(busy0), 32'd0);
        end
`endif

        // Seed mix that would zero the LFSR must load the seed instead
        @(negedge clk);
        seed = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv = dut.u_lfsr.lfsr_q;
        force dut.u_lfsr.cnt_q = sv;
        @(posedge clk);
        #1;
        check_vec("seed_zero_guard", 32'(dut.u_lfsr.lfsr_q), 32'hACE1);
        release dut.u_lfsr.cnt_q;
        seed = 1'b0;
        @(negedge clk);
        check_vec("seed_nonzero_after", 32'(dut.u_lfsr.lfsr_q != 16'h0000), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
- Upstream supplier of cards to both hand controllers in the blackjack game; draws without replacement from one 52-card deck.
- A free-running LFSR picks each card. The deal button perturbs the LFSR to add entropy.
- One-card-per-request handshake. The game FSM ORs the player and dealer requests into i_drawReq.

Parameters:
- LFSR_SEED, 16'hACE1, LFSR value after reset; also the substitute whenever the LFSR would become zero.
- RESHUFFLE_AT, 0, a draw accepted while o_cardsRemaining <= RESHUFFLE_AT triggers an automatic reshuffle before the pick.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_drawReq  in  1  request one card; sampled only in S_IDLE
- i_shuffleReq  in  1  return all cards to the shoe
- i_seedPulse  in  1  deal-button level; its rising edge mixes entropy into the LFSR
- o_cardValid  out  1  single-cycle pulse; o_card and o_cardPoints are valid in that cycle
- o_card  out  6  {suit[1:0], rank[3:0]}; rank 1=Ace .. 13=King
- o_cardPoints  out  4  Ace=1, ranks 2-10 = face value, J/Q/K = 10
- o_busy  out  1  high in any state other than S_IDLE
- o_cardsRemaining  out  6  undealt cards, 0..52
- o_shoeEmpty  out  1  o_cardsRemaining == 0

Behaviour:
- Reset state: state S_IDLE, dealt bitmap (64 bits) all 0, o_cardsRemaining = 52, LFSR = LFSR_SEED, pending shuffle = 0. All other outputs are 0.
- Card index encoding: 6-bit index {suit, rIdx}. The index is legal when rIdx < 13. Rank = rIdx + 1.
- LFSR: 16-bit Galois, mask 16'hB400, steps every cycle in every state.
- Seed mixing: on a registered rising edge of i_seedPulse, LFSR <= LFSR ^ cycleCounter, where cycleCounter is a 16-bit free-running counter. A zero result loads LFSR_SEED instead.
- S_IDLE:
  - If shuffle is pending or i_shuffleReq is high: go to S_SHUFFLE. A simultaneous i_drawReq is latched as a pending draw.
  - Else if i_drawReq is high (or a draw is pending): if remaining <= RESHUFFLE_AT, go to S_SHUFFLE with the draw kept pending; otherwise go to S_PICK.
- S_SHUFFLE (1 cycle): clear the bitmap, set remaining = 52, clear pending shuffle. Next state is S_PICK if a draw is pending, else S_IDLE.
- S_PICK (1 cycle): candidate = LFSR[5:0].
  - If the candidate is legal and undealt: go to S_DELIVER.
  - Otherwise go to S_PROBE with ptr = candidate.
- S_PROBE: each cycle ptr = ptr + 1, modulo 64, skipping illegal indices (rIdx >= 13). Stop at the first undealt index, then go to S_DELIVER. Worst case is 52 cycles.
- S_DELIVER (1 cycle), then S_IDLE:
  - Register o_card and o_cardPoints; pulse o_cardValid.
  - Set the bitmap bit; decrement remaining; clear the pending draw.
- Latency from request to o_cardValid: 2 cycles best case, 54 worst case, plus 1 if a reshuffle is inserted.
- o_card and o_cardPoints hold their last value until the next delivery.
- i_shuffleReq seen in any state other than S_IDLE sets pending shuffle. It is serviced after the current delivery and never corrupts a card in flight.
- Requester contract: deassert i_drawReq no later than the o_cardValid cycle. A request still high in the next S_IDLE cycle is a new draw.
- i_drawReq while o_busy is high is ignored and not queued.
- Remaining never underflows: a draw at 0 remaining always reshuffles first, whatever the value of RESHUFFLE_AT.
- i_reset_n assertion in any state aborts immediately to the reset state. No o_cardValid is produced for the aborted draw.

Optional Feature:
- Macro: CARD_SHOE_STACKED_DECK_EN.
- When defined:
  - S_PICK uses candidate = ptrStack instead of the LFSR. ptrStack resets to 0, advances like the probe pointer after each delivery, and resets to 0 on shuffle.
  - Cards come out in order: index 0,1,..,12,16,...
  - i_seedPulse has no effect on the candidate.
- When undefined: random picking as above. The stack logic is absent.

Decomposition:
- Shared package card_pkg:
  - card_t (6-bit {suit, rank}), suit_t enum, DECK_SIZE = 52, RANKS_PER_SUIT = 13.
  - LFSR_MASK = 16'hB400.
  - Function card_points(rank) returning 4 bits.
- Sub-module card_shoe_lfsr: LFSR step, edge detection on i_seedPulse, counter XOR and zero guard. Outputs the 16-bit state.

Test Plan:
- Stacked deck (macro defined): reset, then 14 single draws -> o_card ranks 1..13 with suit 0, then {suit 1, rank 1}; o_cardPoints 1,2..10,10,10,10,1; o_cardsRemaining 38.
- Random mode: 52 draws -> 52 distinct legal cards, each o_cardValid exactly one cycle, latency <= 54, o_shoeEmpty = 1. The 53rd draw -> reshuffle inserted, one card delivered, o_cardsRemaining = 51.
- RESHUFFLE_AT = 10: draw down to 10 remaining, request again -> S_SHUFFLE seen, then a card delivered; remaining = 51.
- i_shuffleReq pulsed during S_PROBE -> current card delivered normally; the next S_IDLE goes to S_SHUFFLE; remaining = 52 afterwards.
- i_reset_n low during S_PROBE -> no o_cardValid; remaining = 52, LFSR = 16'hACE1 on release.
- Force LFSR == cycleCounter and pulse i_seedPulse -> LFSR loads 16'hACE1, never 0.
